stx_scale_cntr: RTL and testbench

Post-scale (C) output counter for the Stratix PLL model: consumes the VCO-rate clock and produces a divided output clock whose high and low phases and initial phase offset are set by ports. Sits downstream of the VCO, beside the input divide (N) and feedback (M) counters, and drives one PLL output tap. Fully synchronous single-clock design; the divided clock is a registered level, never a gated clock. Configuration is shadowed so that changes take effect only at period boundaries.

---
 rtl/stx_pll_pkg.sv | 29 ++
 rtl/stx_cntr_timer.sv | 28 ++
 rtl/stx_scale_cntr.sv | 141 ++++++++++++++
 tb/tb_stx_scale_cntr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stx_pll_pkg.sv
// Shared definitions for the Stratix PLL counter models: mode and state
// encodings plus the zero-means-full-range count mapping.
package stx_pll_pkg;

    localparam int unsigned CountWDefault = 8;

    typedef enum logic [1:0] {
        ModeOff      = 2'b00,
        ModeNormal   = 2'b01,
        ModeHoldHigh = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StInit = 2'b01,
        StHigh = 2'b10,
        StLow  = 2'b11
    } state_e;

    // A count of zero stands for the full 2**width range.
    function automatic logic [32:0] expand_cnt(input logic [31:0] value,
                                               input int unsigned width);
        if (value == 32'd0) begin
            return 33'd1 << width;
        end
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/stx_cntr_timer.sv
// Loadable down counter shared by the INIT, HIGH and LOW phases; flags the
// last cycle of a phase when the count reaches one.
module stx_cntr_timer #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] cnt_q;

    // Parks at zero rather than wrapping when left running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign done = (cnt_q == Width'(1));

endmodule

// File: rtl/stx_scale_cntr.sv
// Post-scale (C) counter: divides the VCO clock into a registered output level
// with programmable high, low and initial-delay phases.
module stx_scale_cntr
    import stx_pll_pkg::*;
#(
    parameter int unsigned COUNT_W = CountWDefault
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [COUNT_W-1:0] high_cnt,
    input  logic [COUNT_W-1:0] low_cnt,
    input  logic [COUNT_W-1:0] init_cnt,
    output logic               cout,
    output logic               period_start,
    output logic               running
);

    localparam int unsigned CntW = COUNT_W + 1;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [COUNT_W-1:0] high_q, high_d;
    logic [COUNT_W-1:0] low_q, low_d;
    logic               cout_q, cout_d;
    logic               pstart_q, pstart_d;
    logic               tmr_load;
    logic [CntW-1:0]    tmr_val;
    logic               tmr_done;

    function automatic logic [CntW-1:0] span(input logic [COUNT_W-1:0] v);
        return CntW'(expand_cnt(32'(v), COUNT_W));
    endfunction

    function automatic logic mode_runs(input logic [1:0] m);
        return (m == ModeNormal) || (m == ModeHoldHigh);
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        high_d   = high_q;
        low_d    = low_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!enable) begin
            // Clearing the timer discards whatever was left of the phase.
            state_d  = StIdle;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    mode_d = mode;
                    high_d = high_cnt;
                    low_d  = low_cnt;
                    if (mode_runs(mode)) begin
                        tmr_load = 1'b1;
                        if (init_cnt != '0) begin
                            state_d = StInit;
                            tmr_val = span(init_cnt);
                        end else begin
                            state_d = StHigh;
                            tmr_val = span(high_cnt);
                        end
                    end
                end
                StInit: begin
                    if (tmr_done) begin
                        state_d  = StHigh;
                        tmr_load = 1'b1;
                        tmr_val  = span(high_q);
                    end
                end
                StHigh: begin
                    if (mode_q == ModeHoldHigh) begin
                        // Holding: only a mode change releases the output.
                        if (mode != ModeHoldHigh) begin
                            mode_d   = mode;
                            high_d   = high_cnt;
                            low_d    = low_cnt;
                            state_d  = StLow;
                            tmr_load = 1'b1;
                            tmr_val  = span(low_cnt);
                        end
                    end else if (tmr_done) begin
                        state_d  = StLow;
                        tmr_load = 1'b1;
                        tmr_val  = span(low_q);
                    end
                end
                StLow: begin
                    if (tmr_done) begin
                        mode_d   = mode;
                        high_d   = high_cnt;
                        low_d    = low_cnt;
                        tmr_load = 1'b1;
                        tmr_val  = span(high_cnt);
                        state_d  = mode_runs(mode) ? StHigh : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        cout_d   = enable && (state_q == StHigh);
        pstart_d = cout_d && !cout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            mode_q   <= '0;
            high_q   <= '0;
            low_q    <= '0;
            cout_q   <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            high_q   <= high_d;
            low_q    <= low_d;
            cout_q   <= cout_d;
            pstart_q <= pstart_d;
        end
    end

    stx_cntr_timer #(
        .Width(CntW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    assign cout         = cout_q;
    assign period_start = pstart_q;
    assign running      = (state_q != StIdle);

endmodule

// File: tb/tb_stx_scale_cntr.sv
// Bench for stx_scale_cntr: directed scenarios plus random traffic, all checked
// cycle by cycle against a phase/remaining-cycles reference model.
module tb_stx_scale_cntr;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] high_cnt = '0;
    logic [W-1:0] low_cnt = '0;
    logic [W-1:0] init_cnt = '0;
    logic         cout, period_start, running;

    int tests = 0;
    int fails = 0;

    stx_scale_cntr #(
        .COUNT_W(W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .mode        (mode),
        .high_cnt    (high_cnt),
        .low_cnt     (low_cnt),
        .init_cnt    (init_cnt),
        .cout        (cout),
        .period_start(period_start),
        .running     (running)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 delay, 2 high, 3 low; left = cycles remaining in phase.
    int m_phase = 0;
    int m_left = 0;
    int m_mode = 0;
    int m_hi = 0;
    int m_lo = 0;
    bit m_cout = 1'b0;
    bit m_ps = 1'b0;

    function automatic int span(input int v);
        return (v == 0) ? 256 : v;
    endfunction

    function automatic bit runs(input int md);
        return (md == 1) || (md == 2);
    endfunction

    task automatic relatch();
        m_mode = int'(mode);
        m_hi   = span(int'(high_cnt));
        m_lo   = span(int'(low_cnt));
    endtask

    task automatic model_edge();
        bit was_high;
        int md;
        was_high = (m_phase == 2);
        md = int'(mode);
        if (!enable) begin
            m_phase = 0;
            m_left  = 0;
        end else if (m_phase == 0) begin
            relatch();
            if (runs(md)) begin
                if (init_cnt != 0) begin
                    m_phase = 1;
                    m_left  = int'(init_cnt);
                end else begin
                    m_phase = 2;
                    m_left  = m_hi;
                end
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_phase = 2;
                m_left  = m_hi;
            end
        end else if (m_phase == 2) begin
            if (m_mode == 2) begin
                if (md != 2) begin
                    relatch();
                    m_phase = 3;
                    m_left  = m_lo;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = 3;
                    m_left  = m_lo;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                relatch();
                m_phase = runs(md) ? 2 : 0;
                m_left  = m_hi;
            end
        end
        m_ps   = enable && was_high && !m_cout;
        m_cout = enable && was_high;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cout", cout, m_cout);
        chk("period_start", period_start, m_ps);
        chk("running", running, m_phase != 0);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        m_phase = 0; m_left = 0; m_mode = 0; m_hi = 0; m_lo = 0;
        m_cout = 1'b0; m_ps = 1'b0;
        chk("rst_cout", cout, 1'b0);
        chk("rst_period_start", period_start, 1'b0);
        chk("rst_running", running, 1'b0);
        @(negedge clk) reset_n = 1'b1;
    endtask

    // Counts consecutive cycles with cout at lvl; bounded so a stuck output still ends.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (cout === lvl && n < 1000) begin
            n++;
            step();
        end
    endtask

    initial begin
        logic [4:0] pat_a;
        int n;
        int ps_seen;

        #1;
        chk("init_cout", cout, 1'b0);
        chk("init_period_start", period_start, 1'b0);
        chk("init_running", running, 1'b0);
        @(negedge clk) reset_n = 1'b1;

        // NORMAL 2/3, no delay: 1,1,0,0,0 repeating starting one edge after start.
        enable = 1'b1; mode = 2'b01; high_cnt = 8'd2; low_cnt = 8'd3; init_cnt = 8'd0;
        step();
        pat_a = 5'b00011;
        ps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("patA_cout", cout, pat_a[i % 5]);
            if (period_start) ps_seen++;
        end
        chk_int("patA_pstarts", ps_seen, 2);

        enable = 1'b0;
        step();
        chk("disable_cout", cout, 1'b0);
        chk("disable_running", running, 1'b0);

        // Reset during LOW with 3/2, then restart: first rise one edge after start.
        enable = 1'b1; high_cnt = 8'd3; low_cnt = 8'd2;
        for (int i = 0; i < 5; i++) step();
        do_reset();
        step();
        step();
        chk("rst_restart_cout", cout, 1'b1);
        chk("rst_restart_ps", period_start, 1'b1);

        // Initial delay of 4 with 1/1: first period_start five edges after start.
        do_reset();
        init_cnt = 8'd4; high_cnt = 8'd1; low_cnt = 8'd1;
        step();
        n = 0;
        while (period_start !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk_int("init4_first_rise", n, 5);
        for (int i = 0; i < 6; i++) step();
        init_cnt = 8'd0;

        // Zero counts mean 256 high and 256 low.
        enable = 1'b0; step();
        enable = 1'b1; high_cnt = 8'd0; low_cnt = 8'd0;
        step();
        step();
        run_len(1'b1, n);
        chk_int("full_high_len", n, 256);
        run_len(1'b0, n);
        chk_int("full_low_len", n, 256);
        chk("full_rise_ps", period_start, 1'b1);

        // high changed mid-HIGH: this period keeps 2, the next uses 5.
        enable = 1'b0; step();
        enable = 1'b1; high_cnt = 8'd2; low_cnt = 8'd3;
        step();
        step();
        high_cnt = 8'd5;
        run_len(1'b1, n);
        chk_int("chg_high_cur", n, 2);
        run_len(1'b0, n);
        chk_int("chg_low", n, 3);
        run_len(1'b1, n);
        chk_int("chg_high_next", n, 5);

        // NORMAL -> HOLD_HIGH during LOW: one rise, then held high.
        mode = 2'b10;
        ps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (period_start) ps_seen++;
        end
        chk_int("hold_pstarts", ps_seen, 1);
        chk("hold_cout", cout, 1'b1);

        // HOLD_HIGH -> OFF: low count of 3, then back to idle.
        mode = 2'b00;
        for (int i = 0; i < 3; i++) step();
        chk("off_still_running", running, 1'b1);
        step();
        chk("off_idle_running", running, 1'b0);
        chk("off_idle_cout", cout, 1'b0);

        // Random traffic, including mode 11, mid-period changes, drops and resets.
        for (int seg = 0; seg < 40; seg++) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            enable   = ($urandom_range(0, 7) != 0);
            mode     = 2'($urandom_range(0, 3));
            high_cnt = 8'($urandom_range(1, 6));
            low_cnt  = 8'($urandom_range(1, 6));
            init_cnt = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
                step();
                case ($urandom_range(0, 19))
                    0: mode = 2'($urandom_range(0, 3));
                    1: high_cnt = 8'($urandom_range(1, 6));
                    2: low_cnt = 8'($urandom_range(1, 6));
                    3: enable = ~enable;
                    default: ;
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
